// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM:
// state enum, ALUOP codes, opcodes and datapath mux select encodings.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] ALUOP_ADD   = 6'h00;
    localparam logic [5:0] ALUOP_SUB   = 6'h01;
    localparam logic [5:0] ALUOP_FUNCT = 6'h02;
    localparam logic [5:0] ALUOP_AND   = 6'h03;
    localparam logic [5:0] ALUOP_OR    = 6'h04;
    localparam logic [5:0] ALUOP_SLT   = 6'h05;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic [5:0] imm_aluop(input logic [5:0] op);
        case (op)
            OP_ANDI: imm_aluop = ALUOP_AND;
            OP_ORI:  imm_aluop = ALUOP_OR;
            OP_SLTI: imm_aluop = ALUOP_SLT;
            default: imm_aluop = ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_stall_timer.sv
// Memory stall counter: counts consecutive stalled cycles and flags the
// cycle in which the count reaches STALL_TIMEOUT (0 disables the timeout).
module mips_ctrl_stall_timer #(
    parameter int unsigned STALL_TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_i,
    output logic timeout_o
);

    localparam int unsigned CW = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STALL_TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;

    // The Nth stalled cycle is the one where the count of earlier stalls is N-1.
    assign timeout_o = (STALL_TIMEOUT != 0) && stall_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!stall_i || timeout_o) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Optional illegal-opcode trap state enabled by defining MC_ILLEGAL_TRAP_EN.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [5:0] aluop,
    output logic       mem_timeout,
    output logic [3:0] state_dbg
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       stall;
    logic       timeout;

    assign stall = (state_q inside {S_FETCH, S_MEMRD, S_MEMWR}) && !mem_ready;

    mips_ctrl_stall_timer #(
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) u_stall_timer (
        .clk       (clk),
        .rst       (rst),
        .stall_i   (stall),
        .timeout_o (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_RTYPE:                         state_d = S_EXEC;
                    OP_BEQ:                           state_d = S_BRANCH;
                    OP_J:                             state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:                          state_d = S_TRAP;
`else
                    default:                          state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                if (op_q == OP_LW)      state_d = S_MEMRD;
                else if (op_q == OP_SW) state_d = S_MEMWR;
                else                    state_d = S_FETCH;
            end
            S_MEMRD: begin
                if (mem_ready)    state_d = S_MEMWB;
                else if (timeout) state_d = S_FETCH;
            end
            S_MEMWR:  if (mem_ready || timeout) state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_IEXEC:  state_d = S_IWB;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        pc_source     = PCSRC_ALU;
        aluop         = ALUOP_ADD;
        mem_timeout   = timeout;
        state_dbg     = state_q;
        case (state_q)
            S_FETCH: begin
                mem_read  = !timeout;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMM_SH;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = !timeout;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = !timeout;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_FUNCT;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                aluop         = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                aluop     = imm_aluop(op_q);
            end
            S_IWB:   reg_write = 1'b1;
            default: ;
        endcase
        // Reset forces every output low even though the state register already reads FETCH.
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = '0;
            pc_source     = '0;
            aluop         = '0;
            mem_timeout   = 1'b0;
            state_dbg     = '0;
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal_op = !rst && (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control (STALL_TIMEOUT = 4); honours MC_ILLEGAL_TRAP_EN.
module tb_mips_multicycle_control;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, mem_timeout;
    logic [1:0] alu_src_b, pc_source;
    logic [5:0] aluop;
    logic [3:0] state_dbg;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    mips_multicycle_control #(
        .STALL_TIMEOUT(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .aluop         (aluop),
        .mem_timeout   (mem_timeout),
        .state_dbg     (state_dbg)
`ifdef MC_ILLEGAL_TRAP_EN
        ,
        .illegal_op    (illegal_op)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [24:0] exp;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Expected bundle {pcw,pcwc,iord,mr,mw,irw,rdst,m2r,rw,srca,srcb,pcsrc,aluop,tmo,state}
    function automatic logic [24:0] expect_of(input state_t st, input logic rdy,
                                              input logic tmo, input logic [5:0] iop);
        logic pcw, pcwc, io, mr, mw, irw, rd, m2r, rw, sa;
        logic [1:0] srcb, ps;
        logic [5:0] ao;
        {pcw, pcwc, io, mr, mw, irw, rd, m2r, rw, sa} = '0;
        srcb = 2'b00;
        ps   = 2'b00;
        ao   = 6'h00;
        case (st)
            S_FETCH:  begin mr = !tmo; srcb = 2'b01; pcw = rdy; irw = rdy; end
            S_DECODE: srcb = 2'b11;
            S_MEMADR: begin sa = 1'b1; srcb = 2'b10; end
            S_MEMRD:  begin mr = !tmo; io = 1'b1; end
            S_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
            S_MEMWR:  begin mw = !tmo; io = 1'b1; end
            S_EXEC:   begin sa = 1'b1; ao = 6'h02; end
            S_RWB:    begin rw = 1'b1; rd = 1'b1; end
            S_BRANCH: begin sa = 1'b1; ao = 6'h01; pcwc = 1'b1; ps = 2'b01; end
            S_JUMP:   begin pcw = 1'b1; ps = 2'b10; end
            S_IEXEC:  begin sa = 1'b1; srcb = 2'b10; ao = iop; end
            S_IWB:    rw = 1'b1;
            default:  ;
        endcase
        return {pcw, pcwc, io, mr, mw, irw, rd, m2r, rw, sa, srcb, ps, ao, tmo, st};
    endfunction

    task automatic cyc(input logic [5:0] op, input logic rdy, input state_t st,
                       input string tag, input logic tmo = 1'b0, input logic [5:0] iop = 6'h00);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        opcode    = op;
        mem_ready = rdy;
        e.tag = tag;
        e.exp = expect_of(st, rdy, tmo, iop);
        e.ill = (st == S_TRAP);
        sb.push_back(e);
    endtask

    task automatic rcyc(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b1;
        e.tag = tag;
        e.exp = '0;
        e.ill = 1'b0;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check(mon_e.tag,
                  32'({pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
                       mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, aluop,
                       mem_timeout, state_dbg}),
                  32'(mon_e.exp));
`ifdef MC_ILLEGAL_TRAP_EN
            check({mon_e.tag, "_ill"}, 32'(illegal_op), 32'(mon_e.ill));
`endif
        end
    end

    localparam logic [5:0] XOP = 6'h3f;
    logic [5:0] imm_ops  [4] = '{6'h08, 6'h0c, 6'h0d, 6'h0a};
    logic [5:0] imm_alus [4] = '{6'h00, 6'h03, 6'h04, 6'h05};

    initial begin
        rcyc("rst0");
        rcyc("rst1");
        // R-type interrupted by reset, then rerun to completion
        cyc(XOP, 1, S_FETCH, "r0_fetch");
        cyc(6'h00, 1, S_DECODE, "r0_dec");
        cyc(6'h00, 1, S_EXEC, "r0_exec");
        rcyc("rstmid0");
        rcyc("rstmid1");
        cyc(6'h00, 1, S_FETCH, "r_fetch");
        cyc(6'h00, 1, S_DECODE, "r_dec");
        cyc(6'h00, 1, S_EXEC, "r_exec");
        cyc(6'h00, 1, S_RWB, "r_wb");
        // LW with 3 stall cycles in MEMRD; opcode scrambled after DECODE
        cyc(XOP, 1, S_FETCH, "lw_fetch");
        cyc(6'h23, 1, S_DECODE, "lw_dec");
        cyc(XOP, 1, S_MEMADR, "lw_adr");
        for (int i = 0; i < 3; i++) cyc(XOP, 0, S_MEMRD, $sformatf("lw_stall%0d", i));
        cyc(XOP, 1, S_MEMRD, "lw_rd");
        cyc(XOP, 1, S_MEMWB, "lw_wb");
        // SW
        cyc(XOP, 1, S_FETCH, "sw_fetch");
        cyc(6'h2b, 1, S_DECODE, "sw_dec");
        cyc(XOP, 1, S_MEMADR, "sw_adr");
        cyc(XOP, 1, S_MEMWR, "sw_wr");
        // BEQ and J
        cyc(XOP, 1, S_FETCH, "beq_fetch");
        cyc(6'h04, 1, S_DECODE, "beq_dec");
        cyc(XOP, 1, S_BRANCH, "beq_br");
        cyc(XOP, 1, S_FETCH, "j_fetch");
        cyc(6'h02, 1, S_DECODE, "j_dec");
        cyc(XOP, 1, S_JUMP, "j_jump");
        // Immediate ALU ops
        for (int i = 0; i < 4; i++) begin
            cyc(XOP, 1, S_FETCH, $sformatf("imm%0d_fetch", i));
            cyc(imm_ops[i], 1, S_DECODE, $sformatf("imm%0d_dec", i));
            cyc(XOP, 1, S_IEXEC, $sformatf("imm%0d_exec", i), 1'b0, imm_alus[i]);
            cyc(XOP, 1, S_IWB, $sformatf("imm%0d_wb", i));
        end
        // FETCH timeout on the 4th stalled cycle
        for (int i = 0; i < 3; i++) cyc(XOP, 0, S_FETCH, $sformatf("fto_stall%0d", i));
        cyc(XOP, 0, S_FETCH, "fto_pulse", 1'b1);
        cyc(XOP, 1, S_FETCH, "fto_refetch");
        cyc(6'h02, 1, S_DECODE, "fto_dec");
        cyc(XOP, 1, S_JUMP, "fto_jump");
        // mem_ready in the would-be timeout cycle wins
        for (int i = 0; i < 3; i++) cyc(XOP, 0, S_FETCH, $sformatf("frdy_stall%0d", i));
        cyc(XOP, 1, S_FETCH, "frdy_fetch");
        cyc(6'h04, 1, S_DECODE, "frdy_dec");
        cyc(XOP, 1, S_BRANCH, "frdy_br");
        // MEMRD timeout
        cyc(XOP, 1, S_FETCH, "mto_fetch");
        cyc(6'h23, 1, S_DECODE, "mto_dec");
        cyc(XOP, 1, S_MEMADR, "mto_adr");
        for (int i = 0; i < 3; i++) cyc(XOP, 0, S_MEMRD, $sformatf("mto_stall%0d", i));
        cyc(XOP, 0, S_MEMRD, "mto_pulse", 1'b1);
        // SW with stall in MEMWR
        cyc(XOP, 1, S_FETCH, "sws_fetch");
        cyc(6'h2b, 1, S_DECODE, "sws_dec");
        cyc(XOP, 1, S_MEMADR, "sws_adr");
        cyc(XOP, 0, S_MEMWR, "sws_stall0");
        cyc(XOP, 0, S_MEMWR, "sws_stall1");
        cyc(XOP, 1, S_MEMWR, "sws_wr");
        // Illegal opcode
        cyc(XOP, 1, S_FETCH, "ill_fetch");
        cyc(6'h3f, 1, S_DECODE, "ill_dec");
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) cyc(XOP, 1, S_TRAP, $sformatf("ill_trap%0d", i));
        rcyc("ill_rst");
`endif
        cyc(XOP, 1, S_FETCH, "ill_after");
        cyc(6'h00, 1, S_DECODE, "end_dec");
        cyc(XOP, 1, S_EXEC, "end_exec");

        for (int k = 0; k < 5 && sb.size() != 0; k++) @(negedge clk);
        #1;
        check("drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory access and writeback for each instruction.
- Drives the 6-bit ALUOP consumed by the ALU control stage and all datapath write-enables and mux selects.
- Stalls on a memory ready handshake.

Parameters:
- STALL_TIMEOUT, 0, max cycles to wait for mem_ready in any memory state. 0 means wait forever.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  6  instruction bits [31:26] from the instruction register.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_write  output  1  unconditional PC update.
- pc_write_cond  output  1  PC update if ALU zero (BEQ).
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  load instruction register.
- reg_dst  output  1  write register: 0 = rt, 1 = rd.
- mem_to_reg  output  1  write data: 0 = ALUOut, 1 = MDR.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU operand A: 0 = PC, 1 = A register.
- alu_src_b  output  2  ALU operand B: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- pc_source  output  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- aluop  output  6  operation code to the ALU control stage.
- mem_timeout  output  1  one-cycle pulse when a stall exceeds STALL_TIMEOUT.
- state_dbg  output  4  current state encoding.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst).
- Outputs are Moore: a combinational function of state, plus mem_ready for the gated enables listed below.
- While rst is high, all outputs are 0 and the state is FETCH. On the first clk edge after release, FETCH is active.
- ALUOP codes (shared package):
  - ADD = 6'h00, the PC+4 / address add.
  - SUB = 6'h01.
  - FUNCT = 6'h02, decode the funct field.
  - AND = 6'h03.
  - OR = 6'h04.
  - SLT = 6'h05.
- FETCH:
  - Outputs: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, aluop = ADD, pc_source = 00.
  - ir_write and pc_write assert only in the cycle where mem_ready = 1; the FSM then moves to DECODE. Otherwise it stays in FETCH.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, aluop = ADD (branch target precompute).
  - Next state by opcode:
    - 100011 (LW) and 101011 (SW) go to MEMADR.
    - 000000 (R-type) goes to EXEC.
    - 000100 (BEQ) goes to BRANCH.
    - 000010 (J) goes to JUMP.
    - 001000, 001100, 001101, 001010 (ADDI, ANDI, ORI, SLTI) go to IEXEC.
    - Any other opcode: see Optional Feature.
- MEMADR: alu_src_a = 1, alu_src_b = 10, aluop = ADD. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: mem_read = 1, iord = 1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Goes to FETCH.
- MEMWR: mem_write = 1, iord = 1. Waits for mem_ready, then goes to FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00, aluop = FUNCT. Goes to RWB.
- RWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Goes to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, aluop = SUB, pc_write_cond = 1, pc_source = 01. Goes to FETCH.
- JUMP: pc_write = 1, pc_source = 10. Goes to FETCH.
- IEXEC: alu_src_a = 1, alu_src_b = 10. aluop is ADD, AND, OR or SLT per the opcode latched at DECODE. Goes to IWB.
- IWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Goes to FETCH.
- Opcode latch: opcode is captured into an internal register in DECODE and used in MEMADR and IEXEC. The IR may not be stable afterwards.
- Instruction latency, assuming 1-cycle memory:
  - R-type: 4 cycles. Immediate ALU ops: 4. LW: 5. SW: 4. BEQ: 3. J: 3.
- Timeout:
  - A stall counter increments each cycle in FETCH, MEMRD or MEMWR while mem_ready = 0. It clears on state change.
  - With STALL_TIMEOUT = N > 0, when the counter reaches N: pulse mem_timeout for 1 cycle, deassert requests, return to FETCH.
  - The counter width is clog2(N+1) and must not wrap.
  - mem_ready arriving in the same cycle as the timeout wins: the access completes normally and there is no pulse.
- Reset asserted mid-instruction aborts immediately. No write-enable may be high in the cycle after rst rises.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE goes to TRAP, which has all outputs 0.
  - Adds output illegal_op (1 bit), which is high while in TRAP.
  - TRAP is left only by reset.
- Undefined:
  - An unknown opcode returns to FETCH as a NOP (PC already advanced).
  - illegal_op is absent and TRAP is unreachable.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state enum (4-bit);
  - the ALUOP localparams;
  - the opcode localparams;
  - the alu_src_b and pc_source encodings.
- One natural sub-module: mips_ctrl_stall_timer (counter plus timeout compare).

Test Plan:
- Reset mid-EXEC with rst high for 2 cycles: all outputs read 0 during reset; state_dbg = FETCH after release. R-type opcode 000000 with mem_ready tied 1 then yields EXEC with aluop = 6'h02 in cycle 3.
- LW (100011) with mem_ready low for 3 cycles in MEMRD: mem_read and iord held for 4 cycles; reg_write = 1 and mem_to_reg = 1 exactly one cycle later.
- BEQ (000100): states run FETCH, DECODE, BRANCH, FETCH. In BRANCH, aluop = 6'h01, pc_write_cond = 1, pc_source = 01.
- ORI (001101): IEXEC drives aluop = 6'h04 and alu_src_b = 10. IWB drives reg_write = 1 and reg_dst = 0.
- STALL_TIMEOUT = 4, mem_ready held 0 in FETCH: mem_timeout pulses on the 4th stall cycle and the FSM re-enters FETCH. Variant with mem_ready = 1 in that same cycle: no pulse, DECODE follows.
- Opcode 111111: with MC_ILLEGAL_TRAP_EN, illegal_op = 1 and the FSM stays in TRAP for 10 cycles. Without it, FETCH follows DECODE.
